// File: rtl/pinpong_buf.sv
`default_nettype none
// ============================================================================
// Module      : pinpong_buf
// Description : Two-bank ping-pong buffer. The writer fills one bank while the
//               reader drains the other; whole banks are handed over when a
//               bank is full or closed early by in_last. The reader sees the
//               length of the bank it is draining on out_len.
// Option      : PINPONG_ERR_EN - when defined, ovf/udf are sticky error flags
//               cleared only by rst; when undefined they are tied to 0.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               in_flag/in_dat    - write strobe and data
//               in_last           - close current bank after this word
//               out_flag          - read strobe
//               out_dat           - registered read data
//               out_valid         - out_dat updated by an accepted read
//               out_last          - out_dat is the final word of its bank
//               out_len           - length of the bank being read, 0 if empty
//               empty / full      - reader has no bank / writer has no bank
//               ovf / udf         - rejected write / rejected read seen
// Revision    : 1.0 - initial release
// ============================================================================
module pinpong_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_flag,
    input  logic [WIDTH-1:0] in_dat,
    input  logic             in_last,
    input  logic             out_flag,
    output logic [WIDTH-1:0] out_dat,
    output logic             out_valid,
    output logic             out_last,
    output logic [LW-1:0]    out_len,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             udf
);

    localparam int IW = $clog2(DEPTH);
    localparam int AW = $clog2(2 * DEPTH);
    localparam logic [IW-1:0] C_IDX_LAST = IW'(DEPTH - 1);
    localparam logic [AW-1:0] C_BANK1_BASE = AW'(DEPTH);

    // Storage: bank 0 occupies [0, DEPTH), bank 1 occupies [DEPTH, 2*DEPTH).
    logic [WIDTH-1:0] r_mem [0:2*DEPTH-1];

    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [IW-1:0]    r_wr_idx;
    logic [IW-1:0]    r_rd_idx;
    logic [1:0]       r_ready;
    logic [LW-1:0]    r_len [0:1];
    logic [WIDTH-1:0] r_out_dat;
    logic             r_out_valid;
    logic             r_out_last;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_wr_close;
    logic             w_rd_last;
    logic [LW-1:0]    w_rd_len;
    logic [AW-1:0]    w_wr_addr;
    logic [AW-1:0]    w_rd_addr;

    assign w_full     = r_ready[r_wr_bank];
    assign w_empty    = ~r_ready[r_rd_bank];
    assign w_wr_acc   = in_flag & ~w_full;
    assign w_rd_acc   = out_flag & ~w_empty;
    assign w_wr_close = w_wr_acc & ((r_wr_idx == C_IDX_LAST) | in_last);
    assign w_rd_len   = r_len[r_rd_bank];
    // Last word of the bank when the next index would equal the bank length.
    assign w_rd_last  = ((LW'(r_rd_idx) + LW'(1)) == w_rd_len);
    assign w_wr_addr  = r_wr_bank ? (C_BANK1_BASE + AW'(r_wr_idx)) : AW'(r_wr_idx);
    assign w_rd_addr  = r_rd_bank ? (C_BANK1_BASE + AW'(r_rd_idx)) : AW'(r_rd_idx);

    // Memory is not reset; stale words are unreachable because the reader
    // only ever walks banks that were closed after reset.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[w_wr_addr] <= in_dat;
        end
    end

    // Bank control. An accepted write targets a non-ready bank and an
    // accepted read targets a ready bank, so the two never touch the same
    // r_ready bit in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_idx  <= '0;
            r_rd_idx  <= '0;
            r_ready   <= 2'b00;
            r_len[0]  <= '0;
            r_len[1]  <= '0;
        end else begin
            if (w_wr_acc) begin
                if (w_wr_close) begin
                    r_ready[r_wr_bank] <= 1'b1;
                    r_len[r_wr_bank]   <= LW'(r_wr_idx) + LW'(1);
                    r_wr_bank          <= ~r_wr_bank;
                    r_wr_idx           <= '0;
                end else begin
                    r_wr_idx <= r_wr_idx + IW'(1);
                end
            end
            if (w_rd_acc) begin
                if (w_rd_last) begin
                    r_ready[r_rd_bank] <= 1'b0;
                    r_rd_bank          <= ~r_rd_bank;
                    r_rd_idx           <= '0;
                end else begin
                    r_rd_idx <= r_rd_idx + IW'(1);
                end
            end
        end
    end

    // Read port: data holds unless a read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_dat   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_rd_acc) begin
            r_out_dat   <= r_mem[w_rd_addr];
            r_out_valid <= 1'b1;
            r_out_last  <= w_rd_last;
        end else begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

`ifdef PINPONG_ERR_EN
    logic r_ovf;
    logic r_udf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (in_flag && w_full) begin
                r_ovf <= 1'b1;
            end
            if (out_flag && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign ovf = r_ovf;
    assign udf = r_udf;
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

    assign out_dat   = r_out_dat;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_len   = w_empty ? '0 : w_rd_len;
    assign empty     = w_empty;
    assign full      = w_full;

endmodule
`default_nettype wire

// File: tb/tb_pinpong_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pinpong_buf
// Description : Self-checking bench for pinpong_buf (WIDTH=8, DEPTH=3).
//               Reference model: a queue of written words plus a queue of
//               closed-frame lengths; the writer is blocked when two closed
//               frames are still unread.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pinpong_buf;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int LW    = $clog2(DEPTH + 1);
`ifdef PINPONG_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_flag = 1'b0;
    logic [WIDTH-1:0] in_dat = '0;
    logic             in_last = 1'b0;
    logic             out_flag = 1'b0;
    logic [WIDTH-1:0] out_dat;
    logic             out_valid;
    logic             out_last;
    logic [LW-1:0]    out_len;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             udf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pinpong_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_flag(in_flag), .in_dat(in_dat), .in_last(in_last),
        .out_flag(out_flag), .out_dat(out_dat), .out_valid(out_valid),
        .out_last(out_last), .out_len(out_len), .empty(empty), .full(full),
        .ovf(ovf), .udf(udf)
    );

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] q_data[$];   // all accepted words, oldest first
    int               q_len[$];    // lengths of closed, not fully read frames
    int               wcnt;        // words in the frame being written
    int               rpos;        // read position inside head frame
    logic [WIDTH-1:0] m_dat;
    bit               m_valid, m_last, m_ovf, m_udf;

    function automatic bit m_full();
        return q_len.size() == 2;
    endfunction
    function automatic bit m_empty();
        return q_len.size() == 0;
    endfunction
    function automatic int m_len();
        return (q_len.size() == 0) ? 0 : q_len[0];
    endfunction

    // Drive one clock cycle and advance the model; sampling point is 1ns
    // after the rising edge.
    task automatic cyc(input bit f, input logic [WIDTH-1:0] d, input bit l,
                       input bit r, input bit rs);
        bit was_full, was_empty;
        in_flag = f; in_dat = d; in_last = l; out_flag = r; rst = rs;
        if (rs) begin
            q_data.delete(); q_len.delete();
            wcnt = 0; rpos = 0; m_dat = '0;
            m_valid = 0; m_last = 0; m_ovf = 0; m_udf = 0;
        end else begin
            was_full  = m_full();
            was_empty = m_empty();
            if (r && !was_empty) begin
                m_dat   = q_data.pop_front();
                m_last  = (rpos == q_len[0] - 1);
                m_valid = 1;
                if (m_last) begin
                    void'(q_len.pop_front());
                    rpos = 0;
                end else begin
                    rpos++;
                end
            end else begin
                m_valid = 0;
                m_last  = 0;
                if (r) m_udf = 1;
            end
            if (f && !was_full) begin
                q_data.push_back(d);
                wcnt++;
                if (wcnt == DEPTH || l) begin
                    q_len.push_back(wcnt);
                    wcnt = 0;
                end
            end else if (f) begin
                m_ovf = 1;
            end
        end
        @(posedge clk);
        #1;
        in_flag = 0; in_last = 0; out_flag = 0; rst = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        n_checks++;
        if (empty !== 1'b1 || full !== 1'b0 || out_len !== '0) begin
            n_errors++;
            $display("FAIL reset_status: empty=%b full=%b len=%0d, want 1 0 0", empty, full, out_len);
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_dat !== '0 || ovf !== 1'b0 || udf !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: valid=%b last=%b dat=%h ovf=%b udf=%b, want all 0",
                     out_valid, out_last, out_dat, ovf, udf);
        end
    endtask

    task automatic test_fill_drain();
        logic [WIDTH-1:0] exp_d [3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (empty !== 1'b1) begin
                n_errors++;
                $display("FAIL fill_empty[%0d]: got %b want 1", i, empty);
            end
            cyc(1, exp_d[i], 0, 0, 0);
        end
        n_checks++;
        if (empty !== 1'b0 || out_len !== LW'(3)) begin
            n_errors++;
            $display("FAIL fill_len: empty=%b len=%0d, want 0 3", empty, out_len);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0);
            n_checks++;
            if (out_valid !== 1'b1 || out_dat !== exp_d[i] || out_last !== (i == 2)) begin
                n_errors++;
                $display("FAIL drain[%0d]: valid=%b dat=%h last=%b, want 1 %h %b",
                         i, out_valid, out_dat, out_last, exp_d[i], (i == 2));
            end
        end
        n_checks++;
        if (empty !== 1'b1 || out_len !== '0) begin
            n_errors++;
            $display("FAIL drain_empty: empty=%b len=%0d, want 1 0", empty, out_len);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 6; i++) cyc(1, WIDTH'(i), 0, 0, 0);
        n_checks++;
        if (full !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_full: got %b want 1", full);
        end
        cyc(1, 8'h77, 0, 0, 0);
        n_checks++;
        if (ovf !== ERR_EN || full !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_flag: ovf=%b full=%b, want %b 1", ovf, full, ERR_EN);
        end
        for (int i = 1; i <= 6; i++) begin
            cyc(0, 0, 0, 1, 0);
            n_checks++;
            if (out_valid !== 1'b1 || out_dat !== WIDTH'(i) || out_last !== (i == 3 || i == 6)) begin
                n_errors++;
                $display("FAIL ovf_drain[%0d]: valid=%b dat=%h last=%b, want 1 %h %b",
                         i, out_valid, out_dat, out_last, WIDTH'(i), (i == 3 || i == 6));
            end
            n_checks++;
            if (full !== m_full()) begin
                n_errors++;
                $display("FAIL ovf_full_fall[%0d]: got %b want %b", i, full, m_full());
            end
        end
        cyc(0, 0, 0, 0, 1);
    endtask

    task automatic test_short_bank();
        cyc(1, 8'hA1, 1, 0, 0);
        n_checks++;
        if (out_len !== LW'(1) || empty !== 1'b0) begin
            n_errors++;
            $display("FAIL short_len: len=%0d empty=%b, want 1 0", out_len, empty);
        end
        // Read 0xA1 while starting the next frame in the other bank.
        cyc(1, 8'hC0, 0, 1, 0);
        n_checks++;
        if (out_valid !== 1'b1 || out_dat !== 8'hA1 || out_last !== 1'b1) begin
            n_errors++;
            $display("FAIL short_read: valid=%b dat=%h last=%b, want 1 a1 1", out_valid, out_dat, out_last);
        end
        cyc(1, 8'hC1, 0, 0, 0);
        cyc(1, 8'hC2, 0, 0, 0);
        n_checks++;
        if (out_len !== LW'(3)) begin
            n_errors++;
            $display("FAIL short_next_len: got %0d want 3", out_len);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0);
            n_checks++;
            if (out_dat !== WIDTH'(8'hC0 + i) || out_last !== (i == 2)) begin
                n_errors++;
                $display("FAIL short_next[%0d]: dat=%h last=%b, want %h %b",
                         i, out_dat, out_last, WIDTH'(8'hC0 + i), (i == 2));
            end
        end
    endtask

    task automatic test_back_to_back();
        int nread = 0;
        for (int i = 0; i < 3; i++) cyc(1, WIDTH'(8'hE0 + i), 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            logic [WIDTH-1:0] want;
            want = (nread < 3) ? WIDTH'(8'hE0 + nread) : WIDTH'(8'h10 + nread - 3);
            cyc(i < 12, WIDTH'(8'h10 + i), 0, 1, 0);
            n_checks++;
            if (out_valid !== 1'b1 || out_dat !== want || full !== 1'b0 || out_last !== (nread % 3 == 2)) begin
                n_errors++;
                $display("FAIL stream[%0d]: valid=%b dat=%h full=%b last=%b, want 1 %h 0 %b",
                         i, out_valid, out_dat, full, out_last, want, (nread % 3 == 2));
            end
            nread++;
        end
        n_checks++;
        if (empty !== 1'b1) begin
            n_errors++;
            $display("FAIL stream_end_empty: got %b want 1", empty);
        end
    endtask

    task automatic test_underflow();
        logic [WIDTH-1:0] held;
        held = out_dat;
        cyc(0, 0, 0, 1, 0);
        n_checks++;
        if (out_valid !== 1'b0 || out_dat !== held || udf !== ERR_EN) begin
            n_errors++;
            $display("FAIL underflow: valid=%b dat=%h udf=%b, want 0 %h %b", out_valid, out_dat, udf, held, ERR_EN);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) cyc(1, WIDTH'(8'h50 + i), 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        n_checks++;
        if (empty !== 1'b1 || full !== 1'b0 || out_len !== '0 || ovf !== 1'b0 || udf !== 1'b0 ||
            out_valid !== 1'b0 || out_last !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: empty=%b full=%b len=%0d ovf=%b udf=%b valid=%b last=%b",
                     empty, full, out_len, ovf, udf, out_valid, out_last);
        end
        for (int i = 0; i < 3; i++) cyc(1, WIDTH'(8'hB0 + i), 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0);
            n_checks++;
            if (out_valid !== 1'b1 || out_dat !== WIDTH'(8'hB0 + i)) begin
                n_errors++;
                $display("FAIL reset_mid_read[%0d]: valid=%b dat=%h, want 1 %h", i, out_valid, out_dat, WIDTH'(8'hB0 + i));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit f, l, r;
            f = ($urandom_range(0, 99) < 60);
            l = ($urandom_range(0, 99) < 20);
            r = ($urandom_range(0, 99) < 50);
            cyc(f, WIDTH'($urandom), l, r, ($urandom_range(0, 299) == 0));
            n_checks++;
            if (out_valid !== m_valid || (m_valid && (out_dat !== m_dat || out_last !== m_last)) ||
                empty !== m_empty() || full !== m_full() || out_len !== LW'(m_len()) ||
                ovf !== (m_ovf & ERR_EN) || udf !== (m_udf & ERR_EN)) begin
                n_errors++;
                $display("FAIL random[%0d]: v=%b d=%h l=%b e=%b f=%b len=%0d o=%b u=%b; want v=%b d=%h l=%b e=%b f=%b len=%0d o=%b u=%b",
                         i, out_valid, out_dat, out_last, empty, full, out_len, ovf, udf,
                         m_valid, m_dat, m_last, m_empty(), m_full(), m_len(),
                         m_ovf & ERR_EN, m_udf & ERR_EN);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_short_bank();
        test_back_to_back();
        test_underflow();
        test_reset_mid();
        cyc(0, 0, 0, 0, 1);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
